hamming74_encoder: RTL and testbench
====================================

# hamming74_encoder

Streaming Hamming(7,4) encoder, the transmit-side counterpart of the team's Hamming(7,4) decoder. It accepts 4-bit data words over a valid/ready handshake, computes three parity bits and emits a 7-bit codeword through a 2-entry output buffer. Any single codeword bit can optionally be flipped (error injection) so the encoder can drive decoder correction tests. It sits between the data source and the channel/decoder, and its codeword bit layout is identical to the decoder's.

## Interface
- `CNT_W`, default 8: width of the delivered-codeword counter.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  encoder can accept a word this cycle.
- `in_data`  in  4  data nibble `{d3,d2,d1,d0}`.
- `inj_pos`  in  3  error-injection position, sampled with `in_data`. 0 means no error; 1..7 flips codeword bit `inj_pos-1`.
- `out_valid`  out  1  `out_code` is valid.
- `out_ready`  in  1  sink accepts `out_code` this cycle.
- `out_code`  out  7  codeword.
- `out_count`  out  CNT_W  number of codewords delivered, modulo 2^CNT_W.

## Operation
- Codeword layout; bit i is Hamming position i+1:
  - `[0]=p1`, `[1]=p2`, `[2]=d0`, `[3]=p3`, `[4]=d1`, `[5]=d2`, `[6]=d3`.
- Parity is even parity over the covered positions:
  - `p1=d0^d1^d3`
  - `p2=d0^d2^d3`
  - `p3=d1^d2^d3`
- Parity is always computed on clean data. The injection XOR is applied afterwards and only to the stored word. `inj_pos` values 1..7 are all legal; a flipped parity bit is a legitimate test case.
- Accept: `in_valid && in_ready`. Deliver: `out_valid && out_ready`.
- Output buffer is a 2-entry FIFO, controlled by an occupancy FSM:
  - EMPTY:
    - accept → ONE.
  - ONE:
    - accept and no deliver → FULL.
    - deliver and no accept → EMPTY.
    - both → ONE; the head is replaced by the new word, so order is preserved.
  - FULL:
    - deliver → ONE.
    - accept is impossible because `in_ready=0`.
- `in_ready = (state != FULL)`. It is a registered-state decode only, with no combinational path from `out_ready`.
- `out_valid = (state != EMPTY)`. `out_code` is the head entry and stays stable while `out_valid && !out_ready`.
- `out_count` increments by 1 on every deliver and wraps from 2^CNT_W-1 to 0.
- Reset (asynchronous assert, any time including mid-transfer):
  - state goes to EMPTY.
  - `out_valid=0`, `in_ready=1`, `out_code=0`, `out_count=0`.
  - all buffered words are discarded.
- Deassertion is synchronised by the team's standard reset synchroniser upstream. The block only requires that `reset` is released synchronously to `clk`.

## Timing
- Latency: a word accepted at edge N appears on `out_code`, with `out_valid=1`, after edge N, provided the buffer was EMPTY.
- Throughput: 1 codeword/cycle while `out_ready=1`.
- Backpressure: with `out_ready=0`, two words are accepted and `in_ready` falls after the second accept.
- After a deliver from FULL, `in_ready` rises the following cycle.
- `in_data` and `inj_pos` must be stable only in the cycle of acceptance.
- `out_count` updates on the same edge that completes the deliver.

## Structure
- Shared package `hamming_pkg` holds:
  - codeword bit-position localparams `P1_POS=0`, `P2_POS=1`, `D0_POS=2`, `P3_POS=3`, `D1_POS=4`, `D2_POS=5`, `D3_POS=6`.
  - the occupancy-state enum EMPTY/ONE/FULL.
  - the pure function `hamming74_encode(4-bit) → 7-bit`.
- The decoder reuses the position constants from the same package.
- One combinational sub-module, `hamming74_parity`, takes data and `inj_pos` and produces the injected codeword. The FIFO/FSM and counter live in the top.

## Test plan
- Reset asserted mid-stream with the buffer FULL → immediately `out_valid=0`, `in_ready=1`, `out_count=0`. The first word after release encodes correctly.
- `in_data=4'b1011`, `inj_pos=0`, `out_ready=1` → next cycle `out_code=7'b1010101`, `out_count=1`. Also `4'b0000` → `7'b0000000` and `4'b1111` → `7'b1111111`.
- `in_data=4'b1011` with `inj_pos` set to 1, 2, 5 and 7 → `out_code` is respectively `7'b1010100`, `7'b1010111`, `7'b1000101` and `7'b0010101`.
- Backpressure: hold `out_ready=0` and offer `4'h1`, `4'h2`, `4'h3` → first two accepted, `in_ready=0` holding `4'h3`. Release `out_ready` → codewords for 1, 2, 3 delivered in order with no loss or duplication.
- Simultaneous accept and deliver in state ONE for 20 consecutive cycles of random data → one codeword per cycle, state stays ONE, every codeword matches the reference model.
- Deliver 256 codewords with `CNT_W=8` → `out_count` returns to 0 exactly on the 256th deliver.

Source files
------------

// File: rtl/hamming_pkg.sv
// Shared Hamming(7,4) definitions: codeword bit layout, FIFO occupancy
// states and the reference encode function. The decoder uses the same layout.
package hamming_pkg;

  localparam int DATA_NIB_W = 4;
  localparam int CODE_W     = 7;
  localparam int INJ_W      = 3;

  // Codeword bit i holds Hamming position i+1
  localparam int P1_POS = 0;
  localparam int P2_POS = 1;
  localparam int D0_POS = 2;
  localparam int P3_POS = 3;
  localparam int D1_POS = 4;
  localparam int D2_POS = 5;
  localparam int D3_POS = 6;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_state_e;

  // Clean (uninjected) codeword with even parity over each covered group
  function automatic logic [CODE_W-1:0] hamming74_encode(input logic [DATA_NIB_W-1:0] d);
    logic [CODE_W-1:0] c;
    c         = '0;
    c[D0_POS] = d[0];
    c[D1_POS] = d[1];
    c[D2_POS] = d[2];
    c[D3_POS] = d[3];
    c[P1_POS] = d[0] ^ d[1] ^ d[3];
    c[P2_POS] = d[0] ^ d[2] ^ d[3];
    c[P3_POS] = d[1] ^ d[2] ^ d[3];
    return c;
  endfunction

endpackage

// File: rtl/hamming74_encoder_if.sv
// Input data stream, output codeword stream and delivered-count status of the
// Hamming(7,4) encoder. master = source/sink side, slave = encoder side.
interface hamming74_encoder_if
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_NIB_W-1:0] in_data;
  logic [INJ_W-1:0]      inj_pos;
  logic                  out_valid;
  logic                  out_ready;
  logic [CODE_W-1:0]     out_code;
  logic [CNT_W-1:0]      out_count;

  modport master (
    output in_valid, in_data, inj_pos, out_ready,
    input  in_ready, out_valid, out_code, out_count
  );

  modport slave (
    input  in_valid, in_data, inj_pos, out_ready,
    output in_ready, out_valid, out_code, out_count
  );

endinterface

// File: rtl/hamming74_parity.sv
// Combinational Hamming(7,4) encode followed by optional single-bit flip.
// Parity always comes from clean data; the flip is applied last.
module hamming74_parity
  import hamming_pkg::*;
(
  input  logic [DATA_NIB_W-1:0] data,
  input  logic [INJ_W-1:0]      inj_pos,
  output logic [CODE_W-1:0]     code
);

  logic [CODE_W-1:0] flip_mask;

  // One-hot flip mask: inj_pos 1..7 selects bit inj_pos-1, 0 selects nothing
  always_comb begin
    flip_mask = '0;
    for (int i = 0; i < CODE_W; i++) begin
      flip_mask[i] = (inj_pos == INJ_W'(i + 1));
    end
  end

  assign code = hamming74_encode(data) ^ flip_mask;

endmodule

// File: rtl/hamming74_encoder.sv
// Streaming Hamming(7,4) encoder with a 2-entry output FIFO and a
// delivered-codeword counter. Ready/valid are pure decodes of the occupancy
// state, so there is no combinational path from out_ready to in_ready.
module hamming74_encoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  hamming74_encoder_if.slave  bus
);

  occ_state_e        state_q, state_d;
  logic [CODE_W-1:0] head_q, head_d;
  logic [CODE_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CODE_W-1:0] enc_code;
  logic              accept;
  logic              deliver;

  hamming74_parity u_parity (
    .data    (bus.in_data),
    .inj_pos (bus.inj_pos),
    .code    (enc_code)
  );

  assign bus.in_ready  = (state_q != FULL);
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_code  = head_q;
  assign bus.out_count = count_q;

  assign accept  = bus.in_valid && bus.in_ready;
  assign deliver = bus.out_valid && bus.out_ready;

  // Next occupancy, FIFO contents and delivered count
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (deliver) begin
      count_d = count_q + CNT_W'(1);
    end
    case (state_q)
      EMPTY: begin
        if (accept) begin
          head_d  = enc_code;
          state_d = ONE;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          // Head leaves as the new word arrives: it becomes the new head
          head_d = enc_code;
        end else if (accept) begin
          tail_d  = enc_code;
          state_d = FULL;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          head_d  = tail_q;
          state_d = ONE;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // State, buffer and counter registers; reset clears everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_hamming74_encoder.sv
// Bench for hamming74_encoder: queue-based reference FIFO with a
// position-rule Hamming encoder, per-cycle compare, directed and random stimulus.
module tb_hamming74_encoder;

  localparam int CNT_W = 8;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  hamming74_encoder_if #(.CNT_W(CNT_W)) bus ();

  hamming74_encoder #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [6:0] m_q[$];
  int         m_cnt_i = 0;
  int         m_del   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Hamming positions 1..7: powers of two carry parity, others carry d0..d3
  // in order; parity 2^b covers every position with bit b set.
  function automatic logic [6:0] ref_encode(input logic [3:0] d, input int inj);
    logic [7:1] w;
    int k;
    w = '0;
    k = 0;
    for (int p = 1; p <= 7; p++) begin
      if ((p & (p - 1)) != 0) begin
        w[p] = d[k];
        k++;
      end
    end
    for (int b = 0; b < 3; b++) begin
      logic par;
      par = 1'b0;
      for (int p = 1; p <= 7; p++) begin
        if (((p >> b) & 1) == 1 && p != (1 << b)) par = par ^ w[p];
      end
      w[1 << b] = par;
    end
    if (inj != 0) w[inj] = ~w[inj];
    return w;
  endfunction

  // Reference FIFO: updated on each clock edge, cleared by reset
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q.delete();
      m_cnt_i = 0;
    end else begin
      bit acc;
      bit del;
      acc = bus.in_valid && (m_q.size() < 2);
      del = bus.out_ready && (m_q.size() > 0);
      if (del) begin
        void'(m_q.pop_front());
        m_cnt_i = (m_cnt_i + 1) % (1 << CNT_W);
        m_del++;
      end
      if (acc) m_q.push_back(ref_encode(bus.in_data, int'(bus.inj_pos)));
    end
  end

  // Per-cycle compare of all outputs against the reference
  always @(negedge clk) begin
    check("in_ready", 32'(bus.in_ready), 32'(m_q.size() < 2));
    check("out_valid", 32'(bus.out_valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) check("out_code", 32'(bus.out_code), 32'(m_q[0]));
    check("out_count", 32'(bus.out_count), 32'(m_cnt_i));
  end

  task automatic send_one(input logic [3:0] d, input logic [2:0] inj,
                          input logic [6:0] exp, input string name);
    int c0;
    c0 = m_cnt_i;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.inj_pos   = inj;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_data  = 4'($urandom);
    bus.inj_pos  = 3'($urandom);
    check({name, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, "_code"}, 32'(bus.out_code), 32'(exp));
    @(posedge clk); #1;
    check({name, "_count"}, 32'(bus.out_count), 32'((c0 + 1) % 256));
    check({name, "_drained"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int c0;
    int d0;
    bit hit;
    reset         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.inj_pos   = '0;
    bus.out_ready = 1'b0;

    // Pin the reference encoder to hand-computed codewords
    check("model_1011", 32'(ref_encode(4'b1011, 0)), 32'h55);
    check("model_0001", 32'(ref_encode(4'b0001, 0)), 32'h07);
    check("model_0010", 32'(ref_encode(4'b0010, 0)), 32'h19);
    check("model_0011", 32'(ref_encode(4'b0011, 0)), 32'h1E);
    check("model_1011_i5", 32'(ref_encode(4'b1011, 5)), 32'h45);

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_code", 32'(bus.out_code), 32'd0);
    check("rst_out_count", 32'(bus.out_count), 32'd0);
    reset = 1'b1;

    // Clean encodes and every class of injected flip
    send_one(4'b1011, 3'd0, 7'b1010101, "enc_1011");
    send_one(4'b0000, 3'd0, 7'b0000000, "enc_0000");
    send_one(4'b1111, 3'd0, 7'b1111111, "enc_1111");
    send_one(4'b1011, 3'd1, 7'b1010100, "inj1");
    send_one(4'b1011, 3'd2, 7'b1010111, "inj2");
    send_one(4'b1011, 3'd5, 7'b1000101, "inj5");
    send_one(4'b1011, 3'd7, 7'b0010101, "inj7");

    // Backpressure: two words fit, the third waits
    c0 = m_cnt_i;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.inj_pos   = 3'd0;
    bus.in_data   = 4'h1;
    @(posedge clk); #1;
    bus.in_data = 4'h2;
    @(posedge clk); #1;
    bus.in_data = 4'h3;
    check("bp_full_ready", 32'(bus.in_ready), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    check("bp_hold_code", 32'(bus.out_code), 32'h07);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_ready_rise", 32'(bus.in_ready), 32'd1);
    check("bp_code2", 32'(bus.out_code), 32'h19);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_code3", 32'(bus.out_code), 32'h1E);
    @(posedge clk); #1;
    check("bp_empty", 32'(bus.out_valid), 32'd0);
    check("bp_count", 32'(bus.out_count), 32'((c0 + 3) % 256));

    // Reset while FULL, then a clean word afterwards
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'($urandom);
    @(posedge clk); #1;
    bus.in_data = 4'($urandom);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("pre_rst_full", 32'(bus.in_ready), 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("mid_rst_out_count", 32'(bus.out_count), 32'd0);
    check("mid_rst_out_code", 32'(bus.out_code), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    send_one(4'b1011, 3'd0, 7'b1010101, "post_rst");

    // Simultaneous accept and deliver in ONE for 20 cycles
    c0 = m_cnt_i;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_data   = 4'($urandom);
    bus.inj_pos   = 3'($urandom);
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      bus.in_data = 4'($urandom);
      bus.inj_pos = 3'($urandom);
      @(posedge clk); #1;
      check("one_state", {30'd0, bus.in_ready, bus.out_valid}, 32'd3);
    end
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    check("one_count", 32'(bus.out_count), 32'((c0 + 21) % 256));

    // Random traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      bus.in_valid  = 1'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_data   = 4'($urandom);
      bus.inj_pos   = 3'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rand_drained", 32'(bus.out_valid), 32'd0);

    // Counter wrap after 256 delivers from a fresh reset
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    d0  = m_del;
    hit = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      bus.in_data = 4'($urandom);
      bus.inj_pos = 3'($urandom);
      @(posedge clk); #1;
      if (m_del - d0 == 255) begin
        hit = 1'b1;
        break;
      end
    end
    check("wrap_reached_255", 32'(hit), 32'd1);
    check("wrap_count_255", 32'(bus.out_count), 32'd255);
    @(posedge clk); #1;
    check("wrap_count_0", 32'(bus.out_count), 32'd0);
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 200000", $time);
    $fatal(1);
  end

endmodule
